multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multicycle control FSM for the MIPS-subset datapath: sequences each instruction through fetch, decode, execute, memory and write-back over several cycles instead of decoding everything in one cycle. It supports R-type, LW, SW, BEQ, ADDI and J; waits on a memory-ready handshake; traps on illegal opcodes; and counts retired instructions. It sits between the instruction register's opcode field and the shared-ALU/shared-memory datapath.

## Interface
- `OPCODE_W`, 6, opcode field width.
- `ALUOP_W`, 2, ALUOp width to the ALU decoder.
- `CNT_W`, 32, retired-instruction counter width.
- `MEM_WAIT_EN`, 1, when 0 `mem_ready` is ignored and treated as 1.
- `ADDI_EN`, 1, when 0 the ADDI opcode is illegal.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in OPCODE_W: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ior_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` out 1: datapath controls.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `pc_src` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_op` out ALUOP_W: 00 = add, 01 = sub, 10 = funct.
- `halted` out 1: sticky illegal-opcode trap.
- `state_o` out 4: current state encoding, for debug.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP, TRAP.
- FETCH:
  - Controls: mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - pc_write and ir_write are asserted only while mem_ready=1.
  - Go to DECODE when mem_ready=1, else stay.
- DECODE:
  - Controls: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed into ALUOut).
  - Next state by opcode: 100011 or 101011 → MEM_ADDR; 000000 → EXEC; 000100 → BRANCH; 001000 → ADDI_EX (when ADDI_EN); 000010 → JUMP; anything else → TRAP.
- MEM_ADDR:
  - Controls: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - Controls: mem_read=1, ior_d=1.
  - Go to MEM_WB on mem_ready, else stay.
- MEM_WB:
  - Controls: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next: FETCH.
- MEM_WR:
  - Controls: mem_write=1, ior_d=1.
  - Go to FETCH on mem_ready, else stay.
  - mem_write stays asserted through every wait cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Next: FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- JUMP: pc_write=1, pc_src=10. Next: FETCH.
- TRAP: all enables 0, halted=1. Remains in TRAP until reset.
- Default values: every control not listed for a state is 0.
- instret:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH, ADDI_WB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Does not count TRAP.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=FETCH, instret=0, halted=0.
  - While rst_n=0, all write and read enables (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) are forced to 0. Mux selects show their FETCH values.
- Reset deasserted mid-instruction: the instruction is abandoned; fetch restarts on the first clock after release.
- Controls are Moore-decoded from state. Exceptions: pc_write and ir_write in FETCH are combinational in mem_ready.
- Cycles with zero wait states: BEQ 3, J 3, R-type 4, SW 4, ADDI 4, LW 5. Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants (R-type, LW, SW, BEQ, ADDI, J);
  - ALUOp, ALUSrcB and PCSrc encodings.
- Sub-module `mcu_output_decode`: combinational state → control-word decode, including the rst_n and mem_ready gating. The top level holds the state register, next-state logic, instret and halted.

## Test plan
- Reset, then the sequence R-type(000000) → ADDI(001000) → LW(100011) → SW(101011), with mem_ready tied to 1. Required: state trace F,D,EXEC,ALU_WB / F,D,ADDI_EX,ADDI_WB / F,D,MEM_ADDR,MEM_RD,MEM_WB / F,D,MEM_ADDR,MEM_WR, and instret=4 after 17 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD. Required: pc_write and ir_write pulse exactly once; the LW takes 10 cycles; reg_write is asserted for exactly 1 cycle.
- BEQ(000100), then J(000010). Required: 3 cycles each; pc_write_cond=1 with pc_src=01 in BRANCH; pc_write=1 with pc_src=10 in JUMP; instret increments by 2.
- Illegal opcode 111111, then ADDI with ADDI_EN=0. Required: TRAP after DECODE and halted=1 with all enables 0 for 20 cycles. Assert rst_n=0 → halted=0 and state=FETCH immediately, without waiting for a clock.
- rst_n pulsed low during MEM_WR while the write is stalled. Required: mem_write drops to 0 asynchronously, state=FETCH, and instret=0.
- CNT_W=4, run 17 single-cycle-memory J instructions. Required: instret wraps to 1.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit:
// FSM states, opcodes, mux-select encodings and the decoded control word.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // States whose exit to FETCH is unconditional and completes an instruction.
    function automatic logic retires_on_exit(state_t s);
        case (s)
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit (slave) and the datapath/instruction register (master).
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                ior_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic [ALUOP_W-1:0]  alu_op;
    logic                halted;
    logic [3:0]          state_o;
    logic [CNT_W-1:0]    instret;

    modport master (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, halted, state_o, instret
    );

    modport slave (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, halted, state_o, instret
    );
endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// Combinational state -> control-word decode. FETCH's PC/IR writes follow mem_ready
// directly; all enables are held low while reset is asserted.
module mcu_output_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   rst_n_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.ir_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_ADDI_WB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase

        // Mux selects keep their FETCH values during reset; only the enables are gated.
        if (!rst_n_i) begin
            ctrl_o.pc_write      = 1'b0;
            ctrl_o.pc_write_cond = 1'b0;
            ctrl_o.ir_write      = 1'b0;
            ctrl_o.mem_read      = 1'b0;
            ctrl_o.mem_write     = 1'b0;
            ctrl_o.reg_write     = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: state register, opcode-driven next state, sticky trap
// flag and retired-instruction counter. Control decode lives in mcu_output_decode.
module multicycle_control_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int CNT_W       = 32,
    parameter int MEM_WAIT_EN = 1,
    parameter int ADDI_EN     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.slave   bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             halted_q, halted_d;
    logic             mem_ready_eff;
    logic             retire;
    ctrl_t            ctrl;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;

    assign mem_ready_eff = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

    assign is_rtype = (bus.opcode == OPCODE_W'(OP_RTYPE));
    assign is_lw    = (bus.opcode == OPCODE_W'(OP_LW));
    assign is_sw    = (bus.opcode == OPCODE_W'(OP_SW));
    assign is_beq   = (bus.opcode == OPCODE_W'(OP_BEQ));
    assign is_addi  = (bus.opcode == OPCODE_W'(OP_ADDI)) && (ADDI_EN != 0);
    assign is_j     = (bus.opcode == OPCODE_W'(OP_J));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_eff) state_d = S_DECODE;
            S_DECODE: begin
                if (is_lw || is_sw)  state_d = S_MEM_ADDR;
                else if (is_rtype)   state_d = S_EXEC;
                else if (is_beq)     state_d = S_BRANCH;
                else if (is_addi)    state_d = S_ADDI_EX;
                else if (is_j)       state_d = S_JUMP;
                else                 state_d = S_TRAP;
            end
            // Anything other than SW reaching here came from an LW decode.
            S_MEM_ADDR: state_d = is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_eff) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_eff) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    assign retire    = retires_on_exit(state_q) || ((state_q == S_MEM_WR) && mem_ready_eff);
    assign instret_d = retire ? instret_q + 1'b1 : instret_q;
    assign halted_d  = halted_q || (state_d == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
        end
    end

    mcu_output_decode u_decode (
        .state_i     (state_q),
        .rst_n_i     (rst_n),
        .mem_ready_i (mem_ready_eff),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.ior_d         = ctrl.ior_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.alu_op        = ALUOP_W'(ctrl.alu_op);
    assign bus.halted        = halted_q;
    assign bus.state_o       = state_q;
    assign bus.instret       = instret_q;

endmodule
